// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the multi-cycle RV32I-subset controller.
//   state_t  - controller FSM states
//   cls_t    - decoded instruction class
//   OP_*/F3_*/F7_* - opcode and function-field constants
//   ALU_*, IMM_*, WB_*, SRCA_*, SRCB_* - datapath control encodings
package riscv_pkg;

   typedef enum logic [3:0] {
      ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_MADDR,
      ST_MRD, ST_MWR, ST_BRANCH, ST_JUMP, ST_TRAP
   } state_t;

   typedef enum logic [2:0] {
      CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL
   } cls_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_SUB  = 7'h20;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC  = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_RS1   = 2'b01;
   localparam logic [1:0] SRCA_OLDPC = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // funct3 -> ALU operation; sub selects SUB for the 000 slot (R-type only)
   function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
      return (f3 == F3_ADD) ? (sub ? ALU_SUB : ALU_ADD) :
             (f3 == F3_AND) ? ALU_AND :
             (f3 == F3_OR)  ? ALU_OR  : ALU_XOR;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction decode for the multi-cycle controller.
//   i_instr    in  32  IR contents
//   o_cls      out     instruction class
//   o_bne      out 1   branch is BNE (invert EQ for the taken test)
//   o_alu_ctrl out 3   ALU operation for EXEC
//   o_imm_sel  out 3   immediate format for this instruction
//   o_legal    out 1   encoding is in the supported subset
module ctrl_decode
   import riscv_pkg::*;
(
   input  logic [31:0] i_instr,
   output cls_t        o_cls,
   output logic        o_bne,
   output logic [2:0]  o_alu_ctrl,
   output logic [2:0]  o_imm_sel,
   output logic        o_legal
);

   logic [6:0] w_op;
   logic [6:0] w_f7;
   logic [2:0] w_f3;
   logic       w_f3_alu;
   logic       w_unused;

   assign w_op     = i_instr[6:0];
   assign w_f3     = i_instr[14:12];
   assign w_f7     = i_instr[31:25];
   assign w_f3_alu = w_f3 inside {F3_ADD, F3_XOR, F3_OR, F3_AND};
   // register indices are the datapath's business, not the controller's
   assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

   always_comb begin
      o_cls   = CL_ALU_R;
      o_legal = 1'b0;
      case (w_op)
         OP_R: begin
            o_cls   = CL_ALU_R;
            // 0x20 is only meaningful as SUB
            o_legal = w_f3_alu && (w_f7 == F7_BASE || (w_f7 == F7_SUB && w_f3 == F3_ADD));
         end
         OP_I: begin
            o_cls   = CL_ALU_I;
            o_legal = w_f3_alu;
         end
         OP_LW: begin
            o_cls   = CL_LOAD;
            o_legal = w_f3 == F3_WORD;
         end
         OP_SW: begin
            o_cls   = CL_STORE;
            o_legal = w_f3 == F3_WORD;
         end
         OP_BR: begin
            o_cls   = CL_BRANCH;
            o_legal = w_f3 == F3_BEQ || w_f3 == F3_BNE;
         end
         OP_JAL: begin
            o_cls   = CL_JAL;
            o_legal = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_bne      = w_f3 == F3_BNE;
   // bit 30 only selects SUB for R-type; in I-type it is immediate data
   assign o_alu_ctrl = alu_op(w_f3, o_cls == CL_ALU_R && w_f7[5]);
   assign o_imm_sel  = (o_cls == CL_STORE)  ? IMM_S :
                       (o_cls == CL_BRANCH) ? IMM_B :
                       (o_cls == CL_JAL)    ? IMM_J : IMM_I;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle FSM sequencing the RV32I subset
// (ADD SUB AND OR XOR, ADDI ANDI ORI XORI, LW, SW, BEQ, BNE, JAL).
//   clk, rst_n        clock, async active-low reset
//   i_instr  in  32   IR contents
//   i_eq     in  1    ALU equality flag
//   i_mem_ready in 1  memory access completes this cycle
//   o_mem_req/o_mem_we/o_addr_sel  memory handshake and address select
//   o_ir_we/o_pc_we/o_pc_src       IR/PC load controls
//   o_reg_we/o_wb_sel              register writeback
//   o_alu_ctrl/o_alu_src_a/o_alu_src_b/o_imm_sel  ALU operand control
//   o_illegal/o_bus_err            sticky trap causes
module multicycle_ctrl
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] i_instr,
   input  logic                  i_eq,
   input  logic                  i_mem_ready,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic                  o_addr_sel,
   output logic                  o_ir_we,
   output logic                  o_pc_we,
   output logic                  o_pc_src,
   output logic                  o_reg_we,
   output logic [1:0]            o_wb_sel,
   output logic [2:0]            o_alu_ctrl,
   output logic [1:0]            o_alu_src_a,
   output logic [1:0]            o_alu_src_b,
   output logic [2:0]            o_imm_sel,
   output logic                  o_illegal,
   output logic                  o_bus_err
);

   localparam int             WW       = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0]  WAIT_LIM = WW'(MAX_WAIT);

   state_t        r_state;
   state_t        w_next;
   logic [WW-1:0] r_wait;
   logic          r_illegal;
   logic          r_bus_err;
   cls_t          w_cls;
   logic          w_bne;
   logic          w_legal;
   logic [2:0]    w_alu_ctrl;
   logic [2:0]    w_imm_sel;
   logic          w_mem_state;
   logic          w_timeout;

   ctrl_decode u_dec (
      .i_instr    (i_instr),
      .o_cls      (w_cls),
      .o_bne      (w_bne),
      .o_alu_ctrl (w_alu_ctrl),
      .o_imm_sel  (w_imm_sel),
      .o_legal    (w_legal)
   );

   assign w_mem_state = r_state inside {ST_FETCH, ST_MRD, ST_MWR};
   // a ready on the limit cycle completes the access instead of trapping
   assign w_timeout   = w_mem_state && !i_mem_ready && r_wait == WAIT_LIM;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RST;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_addr_sel  = 1'b0;
      o_ir_we     = 1'b0;
      o_pc_we     = 1'b0;
      o_pc_src    = 1'b0;
      o_reg_we    = 1'b0;
      o_wb_sel    = WB_ALU;
      o_alu_ctrl  = ALU_ADD;
      o_alu_src_a = SRCA_PC;
      o_alu_src_b = SRCB_RS2;
      o_imm_sel   = IMM_I;
      case (r_state)
         ST_RST: w_next = ST_FETCH;
         ST_FETCH: begin
            o_mem_req   = 1'b1;
            o_alu_src_b = SRCB_FOUR;
            o_ir_we     = i_mem_ready;
            o_pc_we     = i_mem_ready;
            w_next      = i_mem_ready ? ST_DECODE : w_timeout ? ST_TRAP : ST_FETCH;
         end
         ST_DECODE: begin
            // speculative branch/jump target into ALUOut
            o_alu_src_a = SRCA_OLDPC;
            o_alu_src_b = SRCB_IMM;
            o_imm_sel   = w_imm_sel;
            w_next      = !w_legal                                    ? ST_TRAP   :
                          (w_cls == CL_ALU_R || w_cls == CL_ALU_I)    ? ST_EXEC   :
                          (w_cls == CL_LOAD  || w_cls == CL_STORE)    ? ST_MADDR  :
                          (w_cls == CL_BRANCH)                        ? ST_BRANCH : ST_JUMP;
         end
         ST_EXEC: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_src_b = (w_cls == CL_ALU_R) ? SRCB_RS2 : SRCB_IMM;
            o_alu_ctrl  = w_alu_ctrl;
            w_next      = ST_WB;
         end
         ST_WB: begin
            o_reg_we = 1'b1;
            o_wb_sel = (w_cls == CL_LOAD) ? WB_MEM : WB_ALU;
            w_next   = ST_FETCH;
         end
         ST_MADDR: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_src_b = SRCB_IMM;
            o_imm_sel   = w_imm_sel;
            w_next      = (w_cls == CL_LOAD) ? ST_MRD : ST_MWR;
         end
         ST_MRD: begin
            o_mem_req  = 1'b1;
            o_addr_sel = 1'b1;
            w_next     = i_mem_ready ? ST_WB : w_timeout ? ST_TRAP : ST_MRD;
         end
         ST_MWR: begin
            o_mem_req  = 1'b1;
            o_mem_we   = 1'b1;
            o_addr_sel = 1'b1;
            w_next     = i_mem_ready ? ST_FETCH : w_timeout ? ST_TRAP : ST_MWR;
         end
         ST_BRANCH: begin
            // not-taken leaves the PC+4 already loaded during FETCH
            o_alu_src_a = SRCA_RS1;
            o_alu_src_b = SRCB_RS2;
            o_alu_ctrl  = ALU_SUB;
            o_pc_we     = i_eq ^ w_bne;
            o_pc_src    = 1'b1;
            w_next      = ST_FETCH;
         end
         ST_JUMP: begin
            o_reg_we = 1'b1;
            o_wb_sel = WB_PC;
            o_pc_we  = 1'b1;
            o_pc_src = 1'b1;
            w_next   = ST_FETCH;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait    <= '0;
         r_illegal <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         // any state change restarts the count for the next access; saturates at the limit
         r_wait <= (w_next != r_state) ? '0 :
                   (w_mem_state && !i_mem_ready && r_wait != WAIT_LIM) ? r_wait + 1'b1 : r_wait;
         if (r_state == ST_DECODE && !w_legal) r_illegal <= 1'b1;
         if (w_timeout) r_bus_err <= 1'b1;
      end
   end

   assign o_illegal = r_illegal;
   assign o_bus_err = r_bus_err;

endmodule
